// File: rtl/screens_pkg.sv
// Shared screen codes and defaults for the outer game sequencer and the indications logic.
package screens_pkg;

    typedef enum logic [1:0] {
        SCREEN_START     = 2'd0,
        SCREEN_MAIN      = 2'd1,
        SCREEN_WIN       = 2'd2,
        SCREEN_GAME_OVER = 2'd3
    } screen_t;

    localparam int WIN_SCORE_DEFAULT   = 9;
    localparam int HOLD_FRAMES_DEFAULT = 60;

    // End screens are the ones that hold for a minimum number of frames.
    function automatic logic isEndScreen(input screen_t s);
        return (s == SCREEN_WIN) || (s == SCREEN_GAME_OVER);
    endfunction

endpackage

// File: rtl/key_rise_detector.sv
// Registered key sample with a one-cycle pulse on each rising edge of the key level.
module key_rise_detector (
    input  logic clk,
    input  logic resetN,
    input  logic key,
    output logic keyPress
);

    logic keySample;
    logic keyPrev;
    logic primed;

    // The first edge after reset loads both samples from the key. This means a key
    // that is already held when reset is released is not seen as a new press.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            keySample <= 1'b0;
            keyPrev   <= 1'b0;
            primed    <= 1'b0;
        end else begin
            keySample <= key;
            keyPrev   <= primed ? keySample : key;
            primed    <= 1'b1;
        end
    end

    assign keyPress = keySample & ~keyPrev;

endmodule

// File: rtl/screens_controller.sv
// Outer game state machine: selects the full-screen image and launches each new game.
module screens_controller
    import screens_pkg::*;
#(
    parameter int WIN_SCORE   = WIN_SCORE_DEFAULT,
    parameter int HOLD_FRAMES = HOLD_FRAMES_DEFAULT
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       key5IsPressed,
    input  logic [3:0] life,
    input  logic [3:0] score,
    input  logic [7:0] RGB_screen_main,
    input  logic [7:0] RGB_screen_start,
    input  logic [7:0] RGB_screen_win,
    input  logic [7:0] RGB_screen_game_over,
    output logic       start,
    output logic [1:0] screen,
    output logic [7:0] RGB_out
);

    localparam logic [1:0] ST_START     = SCREEN_START;
    localparam logic [1:0] ST_MAIN      = SCREEN_MAIN;
    localparam logic [1:0] ST_WIN       = SCREEN_WIN;
    localparam logic [1:0] ST_GAME_OVER = SCREEN_GAME_OVER;

    localparam logic [3:0] winThreshold = 4'(WIN_SCORE);
    localparam logic [7:0] holdLimit    = 8'(HOLD_FRAMES);

    logic [1:0] state;
    logic       armed;
    logic [7:0] frameCount;
    logic       keyPress;
    logic       holdDone;

    key_rise_detector key5Detector (
        .clk      (clk),
        .resetN   (resetN),
        .key      (key5IsPressed),
        .keyPress (keyPress)
    );

    assign holdDone = (frameCount == holdLimit);
    assign screen   = state;

    // The armed flag makes sure a life of 0 left over from the previous game cannot
    // end the new game before the main screen has reloaded its lives.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state      <= ST_START;
            start      <= 1'b0;
            armed      <= 1'b0;
            frameCount <= 8'd0;
        end else begin
            start <= 1'b0;
            if (isEndScreen(screen_t'(state)) && startOfFrame && !holdDone) begin
                frameCount <= frameCount + 8'd1;
            end
            case (state)
                ST_START: begin
                    if (keyPress) begin
                        state <= ST_MAIN;
                        start <= 1'b1;
                        armed <= 1'b0;
                    end
                end
                ST_MAIN: begin
                    if (score >= winThreshold) begin
                        state      <= ST_WIN;
                        frameCount <= 8'd0;
                    end else if (armed && (life == 4'd0)) begin
                        state      <= ST_GAME_OVER;
                        frameCount <= 8'd0;
                    end else if (life != 4'd0) begin
                        armed <= 1'b1;
                    end
                end
                default: begin
                    if (keyPress && holdDone) begin
                        state <= ST_START;
                    end
                end
            endcase
        end
    end

    // One register on the pixel path; the VGA stage downstream accounts for it.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            RGB_out <= 8'h00;
        end else begin
            case (state)
                ST_START: RGB_out <= RGB_screen_start;
                ST_MAIN:  RGB_out <= RGB_screen_main;
                ST_WIN:   RGB_out <= RGB_screen_win;
                default:  RGB_out <= RGB_screen_game_over;
            endcase
        end
    end

endmodule

// File: tb/tb_screens_controller.sv
// Self-checking bench for screens_controller: vector table plus hand-written corner-case sequences.
module tb_screens_controller;
    import screens_pkg::*;

    logic       clk = 1'b0;
    logic       resetN;
    logic       startOfFrame;
    logic       key5IsPressed;
    logic [3:0] life;
    logic [3:0] score;
    logic [7:0] rgbMain;
    logic [7:0] rgbStart;
    logic [7:0] rgbWin;
    logic [7:0] rgbGameOver;
    logic       start;
    logic [1:0] screen;
    logic [7:0] RGB_out;

    int         testCount = 0;
    int         failCount = 0;
    logic [7:0] rgbQueue[$];
    logic [1:0] modelScreen;

    typedef struct {
        logic       key;
        logic [3:0] lifeV;
        logic [3:0] scoreV;
        logic       sof;
        logic [1:0] expScreen;
        logic       expStart;
    } vector_t;

    vector_t vectors[11];

    always #5 clk = ~clk;

    screens_controller #(
        .WIN_SCORE   (9),
        .HOLD_FRAMES (60)
    ) dut (
        .clk                  (clk),
        .resetN               (resetN),
        .startOfFrame         (startOfFrame),
        .key5IsPressed        (key5IsPressed),
        .life                 (life),
        .score                (score),
        .RGB_screen_main      (rgbMain),
        .RGB_screen_start     (rgbStart),
        .RGB_screen_win       (rgbWin),
        .RGB_screen_game_over (rgbGameOver),
        .start                (start),
        .screen               (screen),
        .RGB_out              (RGB_out)
    );

    function automatic logic [7:0] pickRgb(input logic [1:0] s);
        case (s)
            2'd0:    return rgbStart;
            2'd1:    return rgbMain;
            2'd2:    return rgbWin;
            default: return rgbGameOver;
        endcase
    endfunction

    task automatic checkValue(input string name, input logic [7:0] actual, input logic [7:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
        end
    endtask

    // Drives one cycle of inputs with fresh, mutually distinct pixels and queues the expected pixel.
    task automatic applyStimulus(input logic key, input logic [3:0] lifeV, input logic [3:0] scoreV,
                                 input logic sof);
        key5IsPressed = key;
        life          = lifeV;
        score         = scoreV;
        startOfFrame  = sof;
        rgbStart      = 8'($urandom);
        rgbMain       = rgbStart ^ 8'h55;
        rgbWin        = rgbStart ^ 8'hAA;
        rgbGameOver   = rgbStart ^ 8'hFF;
        rgbQueue.push_back(pickRgb(modelScreen));
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input logic [1:0] expScreen, input logic expStart);
        logic [7:0] expRgb;
        checkValue("screen", {6'd0, screen}, {6'd0, expScreen});
        checkValue("start", {7'd0, start}, {7'd0, expStart});
        if (rgbQueue.size() == 0) begin
            testCount++;
            failCount++;
            $display("[TB] FAIL rgbScoreboard: got empty queue, expected a pending pixel");
        end else begin
            expRgb = rgbQueue.pop_front();
            checkValue("RGB_out", RGB_out, expRgb);
        end
        modelScreen = expScreen;
    endtask

    task automatic step(input logic key, input logic [3:0] lifeV, input logic [3:0] scoreV,
                        input logic sof, input logic [1:0] expScreen, input logic expStart);
        applyStimulus(key, lifeV, scoreV, sof);
        checkOutput(expScreen, expStart);
    endtask

    // Asserts reset between clock edges and checks the outputs clear before the next edge.
    task automatic midCycleReset(input logic key);
        @(posedge clk);
        #3;
        key5IsPressed = key;
        resetN        = 1'b0;
        #1;
        checkValue("resetScreen", {6'd0, screen}, 8'd0);
        checkValue("resetStart", {7'd0, start}, 8'd0);
        checkValue("resetRgb", RGB_out, 8'h00);
        rgbQueue.delete();
        modelScreen = 2'd0;
        @(posedge clk);
        #3;
        resetN = 1'b1;
    endtask

    initial begin
        vectors[0]  = '{1'b1, 4'd0, 4'd0, 1'b0, 2'd0, 1'b0};
        vectors[1]  = '{1'b1, 4'd0, 4'd0, 1'b0, 2'd1, 1'b1};
        vectors[2]  = '{1'b1, 4'd0, 4'd0, 1'b0, 2'd1, 1'b0};
        vectors[3]  = '{1'b1, 4'd0, 4'd0, 1'b0, 2'd1, 1'b0};
        vectors[4]  = '{1'b1, 4'd0, 4'd0, 1'b0, 2'd1, 1'b0};
        vectors[5]  = '{1'b1, 4'd0, 4'd0, 1'b0, 2'd1, 1'b0};
        vectors[6]  = '{1'b1, 4'd0, 4'd0, 1'b0, 2'd1, 1'b0};
        vectors[7]  = '{1'b1, 4'd3, 4'd0, 1'b0, 2'd1, 1'b0};
        vectors[8]  = '{1'b1, 4'd0, 4'd0, 1'b0, 2'd3, 1'b0};
        vectors[9]  = '{1'b1, 4'd0, 4'd0, 1'b0, 2'd3, 1'b0};
        vectors[10] = '{1'b0, 4'd0, 4'd0, 1'b0, 2'd3, 1'b0};

        resetN        = 1'b0;
        key5IsPressed = 1'b1;
        life          = 4'd0;
        score         = 4'd0;
        startOfFrame  = 1'b0;
        rgbStart      = 8'h12;
        rgbMain       = 8'h34;
        rgbWin        = 8'h56;
        rgbGameOver   = 8'h78;
        modelScreen   = 2'd0;

        repeat (3) @(posedge clk);
        #1;
        checkValue("initScreen", {6'd0, screen}, 8'd0);
        checkValue("initStart", {7'd0, start}, 8'd0);
        checkValue("initRgb", RGB_out, 8'h00);
        #2;
        resetN = 1'b1;

        // Key held through reset release must not start a game.
        for (int i = 0; i < 4; i++) step(1'b1, 4'd0, 4'd0, 1'b0, 2'd0, 1'b0);
        step(1'b0, 4'd0, 4'd0, 1'b0, 2'd0, 1'b0);

        // START -> MAIN with a 10-cycle press, stale zero lives, then GAME_OVER.
        for (int i = 0; i < 11; i++) begin
            step(vectors[i].key, vectors[i].lifeV, vectors[i].scoreV, vectors[i].sof,
                 vectors[i].expScreen, vectors[i].expStart);
        end

        // Hold time in GAME_OVER: presses after 30 and 59 frames are dropped.
        for (int i = 0; i < 30; i++) step(1'b0, 4'd0, 4'd0, 1'b1, 2'd3, 1'b0);
        step(1'b1, 4'd0, 4'd0, 1'b0, 2'd3, 1'b0);
        step(1'b1, 4'd0, 4'd0, 1'b0, 2'd3, 1'b0);
        step(1'b0, 4'd0, 4'd0, 1'b0, 2'd3, 1'b0);
        for (int i = 0; i < 29; i++) step(1'b0, 4'd0, 4'd0, 1'b1, 2'd3, 1'b0);
        step(1'b1, 4'd0, 4'd0, 1'b0, 2'd3, 1'b0);
        step(1'b1, 4'd0, 4'd0, 1'b0, 2'd3, 1'b0);
        step(1'b0, 4'd0, 4'd0, 1'b0, 2'd3, 1'b0);
        step(1'b0, 4'd0, 4'd0, 1'b1, 2'd3, 1'b0);
        step(1'b0, 4'd0, 4'd0, 1'b1, 2'd3, 1'b0);
        step(1'b1, 4'd0, 4'd0, 1'b0, 2'd3, 1'b0);
        step(1'b1, 4'd0, 4'd0, 1'b0, 2'd0, 1'b0);
        step(1'b0, 4'd0, 4'd0, 1'b0, 2'd0, 1'b0);
        step(1'b0, 4'd0, 4'd0, 1'b0, 2'd0, 1'b0);

        // New game, score 8 stays, then score 9 and life 0 together: WIN wins.
        step(1'b1, 4'd0, 4'd0, 1'b0, 2'd0, 1'b0);
        step(1'b1, 4'd0, 4'd0, 1'b0, 2'd1, 1'b1);
        step(1'b0, 4'd3, 4'd0, 1'b0, 2'd1, 1'b0);
        step(1'b0, 4'd3, 4'd8, 1'b0, 2'd1, 1'b0);
        step(1'b0, 4'd0, 4'd9, 1'b0, 2'd2, 1'b0);
        step(1'b0, 4'd0, 4'd9, 1'b1, 2'd2, 1'b0);
        step(1'b1, 4'd0, 4'd9, 1'b1, 2'd2, 1'b0);
        step(1'b1, 4'd0, 4'd9, 1'b0, 2'd2, 1'b0);
        step(1'b0, 4'd0, 4'd9, 1'b0, 2'd2, 1'b0);

        // Reset out of WIN, start a game, then reset mid-frame in MAIN with the key held.
        midCycleReset(1'b0);
        step(1'b0, 4'd0, 4'd0, 1'b0, 2'd0, 1'b0);
        step(1'b1, 4'd0, 4'd0, 1'b0, 2'd0, 1'b0);
        step(1'b1, 4'd2, 4'd1, 1'b0, 2'd1, 1'b1);
        step(1'b0, 4'd2, 4'd1, 1'b1, 2'd1, 1'b0);
        step(1'b0, 4'd2, 4'd1, 1'b0, 2'd1, 1'b0);
        midCycleReset(1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 4'd2, 4'd1, 1'b0, 2'd0, 1'b0);
        step(1'b0, 4'd2, 4'd1, 1'b0, 2'd0, 1'b0);
        step(1'b1, 4'd2, 4'd1, 1'b0, 2'd0, 1'b0);
        step(1'b1, 4'd2, 4'd1, 1'b0, 2'd1, 1'b1);
        step(1'b0, 4'd2, 4'd1, 1'b0, 2'd1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
